// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
//   Decode-side operand fetch. This block holds the architectural register
//   file (x0 hardwired to zero) with NUM_WB write-back ports and same-cycle
//   write-back bypass. It detects load-use hazards with a LOAD_BUBBLES-deep
//   scoreboard and drives a single pipeline register into execute.
//
// Ports
//   of_clk, of_rst        clock, synchronous active-high reset
//   of_i_*                decoded instruction from the decoder
//   of_i_stall/of_i_flush downstream stall and flush
//   of_wb_we/addr/data    NUM_WB packed write-back ports; a higher index
//                         is a younger producer
//   of_o_*                registered instruction and operands to execute
//   of_o_stall/of_o_flush combinational stall and flush back to the decoder
module operand_fetch_stage #(
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned AWIDTH       = 5,
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned NUM_WB       = 2,
  parameter int unsigned LOAD_BUBBLES = 1
) (
  input  logic                     of_clk,
  input  logic                     of_rst,
  input  logic                     of_i_ce,
  input  logic [PC_WIDTH-1:0]      of_i_pc,
  input  logic [AWIDTH-1:0]        of_i_addr_rs1,
  input  logic [AWIDTH-1:0]        of_i_addr_rs2,
  input  logic                     of_i_use_rs1,
  input  logic                     of_i_use_rs2,
  input  logic [AWIDTH-1:0]        of_i_addr_rd,
  input  logic                     of_i_rd_we,
  input  logic                     of_i_is_load,
  input  logic                     of_i_stall,
  input  logic                     of_i_flush,
  input  logic [NUM_WB-1:0]        of_wb_we,
  input  logic [NUM_WB*AWIDTH-1:0] of_wb_addr,
  input  logic [NUM_WB*DWIDTH-1:0] of_wb_data,
  output logic                     of_o_ce,
  output logic [PC_WIDTH-1:0]      of_o_pc,
  output logic [DWIDTH-1:0]        of_o_rs1_data,
  output logic [DWIDTH-1:0]        of_o_rs2_data,
  output logic [AWIDTH-1:0]        of_o_addr_rd,
  output logic                     of_o_rd_we,
  output logic                     of_o_is_load,
  output logic                     of_o_stall,
  output logic                     of_o_flush
);

  localparam int unsigned NREG = 1 << AWIDTH;

  // Register file
  logic [DWIDTH-1:0] r_regs [NREG];

  // Load scoreboard: entry j is a load that left this stage j+1 edges ago
  logic [LOAD_BUBBLES-1:0] r_sb_vld;
  logic [AWIDTH-1:0]       r_sb_rd [LOAD_BUBBLES];

  // Output pipeline register
  logic                r_ce;
  logic [PC_WIDTH-1:0] r_pc;
  logic [DWIDTH-1:0]   r_rs1_data;
  logic [DWIDTH-1:0]   r_rs2_data;
  logic [AWIDTH-1:0]   r_addr_rd;
  logic                r_rd_we;
  logic                r_is_load;
  // Source addresses of the held instruction, used to refresh operands
  // that are overwritten by write-back while execute is stalled
  logic [AWIDTH-1:0]   r_src1;
  logic [AWIDTH-1:0]   r_src2;

  logic [DWIDTH-1:0] w_rs1_byp;
  logic [DWIDTH-1:0] w_rs2_byp;
  logic [DWIDTH-1:0] w_held1;
  logic [DWIDTH-1:0] w_held2;
  logic              w_sb_hit;
  logic              w_hazard;
  logic              w_advance;
  logic              w_capture;
  logic              w_push;

  // Read with bypass. Ports are scanned in ascending order so the last
  // match, the youngest producer, wins.
  always_comb begin
    w_rs1_byp = r_regs[of_i_addr_rs1];
    w_rs2_byp = r_regs[of_i_addr_rs2];
    w_held1   = r_rs1_data;
    w_held2   = r_rs2_data;
    for (int unsigned k = 0; k < NUM_WB; k++) begin
      if (of_wb_we[k]) begin
        if (of_wb_addr[k*AWIDTH +: AWIDTH] == of_i_addr_rs1)
          w_rs1_byp = of_wb_data[k*DWIDTH +: DWIDTH];
        if (of_wb_addr[k*AWIDTH +: AWIDTH] == of_i_addr_rs2)
          w_rs2_byp = of_wb_data[k*DWIDTH +: DWIDTH];
        if (of_wb_addr[k*AWIDTH +: AWIDTH] == r_src1)
          w_held1 = of_wb_data[k*DWIDTH +: DWIDTH];
        if (of_wb_addr[k*AWIDTH +: AWIDTH] == r_src2)
          w_held2 = of_wb_data[k*DWIDTH +: DWIDTH];
      end
    end
    if (of_i_addr_rs1 == '0) w_rs1_byp = '0;
    if (of_i_addr_rs2 == '0) w_rs2_byp = '0;
    if (r_src1 == '0)        w_held1   = r_rs1_data;
    if (r_src2 == '0)        w_held2   = r_rs2_data;
  end

  // Scoreboard entries never hold rd=0, so x0 sources cannot match.
  always_comb begin
    w_sb_hit = 1'b0;
    for (int unsigned j = 0; j < LOAD_BUBBLES; j++) begin
      if (r_sb_vld[j] &&
          ((of_i_use_rs1 && (r_sb_rd[j] == of_i_addr_rs1)) ||
           (of_i_use_rs2 && (r_sb_rd[j] == of_i_addr_rs2))))
        w_sb_hit = 1'b1;
    end
  end

  assign w_hazard  = of_i_ce & w_sb_hit;
  assign w_advance = ~of_i_stall | of_i_flush;
  assign w_capture = ~of_i_flush & ~of_i_stall & ~w_hazard;
  assign w_push    = w_capture & of_i_ce & of_i_is_load & of_i_rd_we &
                     (of_i_addr_rd != '0);

  assign of_o_stall = of_i_stall | w_hazard;
  assign of_o_flush = of_i_flush;

  // Register file write; with equal addresses the later (higher k)
  // non-blocking assignment wins.
  always_ff @(posedge of_clk) begin
    if (of_rst) begin
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_WB; k++) begin
        if (of_wb_we[k] && (of_wb_addr[k*AWIDTH +: AWIDTH] != '0))
          r_regs[of_wb_addr[k*AWIDTH +: AWIDTH]] <= of_wb_data[k*DWIDTH +: DWIDTH];
      end
    end
  end

  // Scoreboard shift; stalled cycles do not age pending loads.
  always_ff @(posedge of_clk) begin
    if (of_rst) begin
      r_sb_vld <= '0;
      for (int unsigned j = 0; j < LOAD_BUBBLES; j++) r_sb_rd[j] <= '0;
    end else if (w_advance) begin
      r_sb_vld[0] <= w_push;
      r_sb_rd[0]  <= of_i_addr_rd;
      for (int unsigned j = 1; j < LOAD_BUBBLES; j++) begin
        r_sb_vld[j] <= r_sb_vld[j-1];
        r_sb_rd[j]  <= r_sb_rd[j-1];
      end
    end
  end

  // Output register: flush > stall (hold + refresh) > hazard bubble > capture
  always_ff @(posedge of_clk) begin
    if (of_rst) begin
      r_ce       <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_addr_rd  <= '0;
      r_rd_we    <= 1'b0;
      r_is_load  <= 1'b0;
      r_src1     <= '0;
      r_src2     <= '0;
    end else if (of_i_flush) begin
      r_ce <= 1'b0;
    end else if (of_i_stall) begin
      r_rs1_data <= w_held1;
      r_rs2_data <= w_held2;
    end else if (w_hazard) begin
      r_ce <= 1'b0;
    end else begin
      r_ce       <= of_i_ce;
      r_pc       <= of_i_pc;
      r_rs1_data <= w_rs1_byp;
      r_rs2_data <= w_rs2_byp;
      r_addr_rd  <= of_i_addr_rd;
      r_rd_we    <= of_i_rd_we;
      r_is_load  <= of_i_is_load;
      r_src1     <= of_i_addr_rs1;
      r_src2     <= of_i_addr_rs2;
    end
  end

  assign of_o_ce       = r_ce;
  assign of_o_pc       = r_pc;
  assign of_o_rs1_data = r_rs1_data;
  assign of_o_rs2_data = r_rs2_data;
  assign of_o_addr_rd  = r_addr_rd;
  assign of_o_rd_we    = r_rd_we;
  assign of_o_is_load  = r_is_load;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: two instances (LOAD_BUBBLES=1 and 2) share
// one stimulus stream and are compared against a behavioural model built on
// a plain register array and a list of pending loads with remaining cycles.
module tb_operand_fetch_stage;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned PW = 32;
  localparam int unsigned NW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, i_ce, use1, use2, rd_we, is_load, i_stall, i_flush;
  logic [PW-1:0] i_pc;
  logic [AW-1:0] rs1, rs2, rd;
  logic [NW-1:0]    wb_we;
  logic [NW*AW-1:0] wb_addr;
  logic [NW*DW-1:0] wb_data;

  logic          o_ce [2];
  logic [PW-1:0] o_pc [2];
  logic [DW-1:0] o_r1 [2];
  logic [DW-1:0] o_r2 [2];
  logic [AW-1:0] o_rd [2];
  logic          o_we [2];
  logic          o_ld [2];
  logic          o_stall [2];
  logic          o_flush [2];

  operand_fetch_stage #(.DWIDTH(DW), .AWIDTH(AW), .PC_WIDTH(PW), .NUM_WB(NW), .LOAD_BUBBLES(1)) u_dut1 (
    .of_clk(clk), .of_rst(rst), .of_i_ce(i_ce), .of_i_pc(i_pc),
    .of_i_addr_rs1(rs1), .of_i_addr_rs2(rs2), .of_i_use_rs1(use1), .of_i_use_rs2(use2),
    .of_i_addr_rd(rd), .of_i_rd_we(rd_we), .of_i_is_load(is_load),
    .of_i_stall(i_stall), .of_i_flush(i_flush),
    .of_wb_we(wb_we), .of_wb_addr(wb_addr), .of_wb_data(wb_data),
    .of_o_ce(o_ce[0]), .of_o_pc(o_pc[0]), .of_o_rs1_data(o_r1[0]), .of_o_rs2_data(o_r2[0]),
    .of_o_addr_rd(o_rd[0]), .of_o_rd_we(o_we[0]), .of_o_is_load(o_ld[0]),
    .of_o_stall(o_stall[0]), .of_o_flush(o_flush[0]));

  operand_fetch_stage #(.DWIDTH(DW), .AWIDTH(AW), .PC_WIDTH(PW), .NUM_WB(NW), .LOAD_BUBBLES(2)) u_dut2 (
    .of_clk(clk), .of_rst(rst), .of_i_ce(i_ce), .of_i_pc(i_pc),
    .of_i_addr_rs1(rs1), .of_i_addr_rs2(rs2), .of_i_use_rs1(use1), .of_i_use_rs2(use2),
    .of_i_addr_rd(rd), .of_i_rd_we(rd_we), .of_i_is_load(is_load),
    .of_i_stall(i_stall), .of_i_flush(i_flush),
    .of_wb_we(wb_we), .of_wb_addr(wb_addr), .of_wb_data(wb_data),
    .of_o_ce(o_ce[1]), .of_o_pc(o_pc[1]), .of_o_rs1_data(o_r1[1]), .of_o_rs2_data(o_r2[1]),
    .of_o_addr_rd(o_rd[1]), .of_o_rd_we(o_we[1]), .of_o_is_load(o_ld[1]),
    .of_o_stall(o_stall[1]), .of_o_flush(o_flush[1]));

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] m_rf [32];
  logic          m_ce [2];
  logic          m_known [2];
  logic [PW-1:0] m_pc [2];
  logic [DW-1:0] m_r1 [2];
  logic [DW-1:0] m_r2 [2];
  logic [AW-1:0] m_a1 [2];
  logic [AW-1:0] m_a2 [2];
  logic [AW-1:0] m_rd [2];
  logic          m_we [2];
  logic          m_ld [2];
  // pending loads: destination and cycles of unavailability left
  logic [AW-1:0] p_rd  [2][4];
  int            p_rem [2][4];
  int            p_n   [2];

  function automatic logic [DW-1:0] wb_d(input int k);
    logic [NW*DW-1:0] v;
    v = wb_data;
    return v[k*DW +: DW];
  endfunction

  function automatic logic [AW-1:0] wb_a(input int k);
    logic [NW*AW-1:0] v;
    v = wb_addr;
    return v[k*AW +: AW];
  endfunction

  // Value an instruction reading address a sees this cycle
  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (a == 0) return '0;
    v = m_rf[a];
    for (int k = 0; k < NW; k++)
      if (wb_we[k] && wb_a(k) == a) v = wb_d(k);
    return v;
  endfunction

  task automatic set_nop();
    rst = 0; i_ce = 0; i_pc = '0; rs1 = '0; rs2 = '0; use1 = 0; use2 = 0;
    rd = '0; rd_we = 0; is_load = 0; i_stall = 0; i_flush = 0;
    wb_we = '0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic set_instr(input logic [PW-1:0] pc, input logic [AW-1:0] a1, input logic u1,
                           input logic [AW-1:0] a2, input logic u2, input logic [AW-1:0] d,
                           input logic we, input logic ld);
    i_ce = 1; i_pc = pc; rs1 = a1; use1 = u1; rs2 = a2; use2 = u2;
    rd = d; rd_we = we; is_load = ld;
  endtask

  task automatic set_wb(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [NW*AW-1:0] va;
    logic [NW*DW-1:0] vd;
    va = wb_addr; vd = wb_data;
    va[k*AW +: AW] = a; vd[k*DW +: DW] = d;
    wb_addr = va; wb_data = vd; wb_we[k] = 1'b1;
  endtask

  task automatic step();
    logic haz [2];
    logic adv, cap;
    logic [DW-1:0] b1, b2;
    int n;
    #1;
    b1 = rd_val(rs1);
    b2 = rd_val(rs2);
    for (int i = 0; i < 2; i++) begin
      haz[i] = 1'b0;
      for (int e = 0; e < p_n[i]; e++)
        if ((use1 && p_rd[i][e] == rs1) || (use2 && p_rd[i][e] == rs2)) haz[i] = 1'b1;
      haz[i] = haz[i] & i_ce;
      chk($sformatf("lb%0d_o_stall", i+1), 64'(o_stall[i]), 64'(i_stall | haz[i]));
      chk($sformatf("lb%0d_o_flush", i+1), 64'(o_flush[i]), 64'(i_flush));
    end
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_ce[i] = 0; m_known[i] = 1; m_pc[i] = '0; m_r1[i] = '0; m_r2[i] = '0;
        m_a1[i] = '0; m_a2[i] = '0; m_rd[i] = '0; m_we[i] = 0; m_ld[i] = 0; p_n[i] = 0;
      end else begin
        adv = !i_stall || i_flush;
        cap = !i_flush && !i_stall && !haz[i];
        if (i_flush) begin
          m_ce[i] = 0; m_known[i] = 0;
        end else if (i_stall) begin
          for (int k = 0; k < NW; k++) begin
            if (wb_we[k] && m_a1[i] != 0 && wb_a(k) == m_a1[i]) m_r1[i] = wb_d(k);
            if (wb_we[k] && m_a2[i] != 0 && wb_a(k) == m_a2[i]) m_r2[i] = wb_d(k);
          end
        end else if (haz[i]) begin
          m_ce[i] = 0; m_known[i] = 0;
        end else begin
          m_ce[i] = i_ce; m_known[i] = 1; m_pc[i] = i_pc; m_r1[i] = b1; m_r2[i] = b2;
          m_a1[i] = rs1; m_a2[i] = rs2; m_rd[i] = rd; m_we[i] = rd_we; m_ld[i] = is_load;
        end
        if (adv) begin
          n = 0;
          for (int e = 0; e < p_n[i]; e++)
            if (p_rem[i][e] > 1) begin
              p_rd[i][n] = p_rd[i][e]; p_rem[i][n] = p_rem[i][e] - 1; n++;
            end
          if (cap && i_ce && is_load && rd_we && rd != 0) begin
            p_rd[i][n] = rd; p_rem[i][n] = i + 1; n++;
          end
          p_n[i] = n;
        end
      end
    end
    if (rst) begin
      for (int r = 0; r < 32; r++) m_rf[r] = '0;
    end else begin
      for (int k = 0; k < NW; k++)
        if (wb_we[k] && wb_a(k) != 0) m_rf[wb_a(k)] = wb_d(k);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("lb%0d_o_ce", i+1), 64'(o_ce[i]), 64'(m_ce[i]));
      if (m_ce[i] || m_known[i]) begin
        chk($sformatf("lb%0d_o_pc", i+1),  64'(o_pc[i]), 64'(m_pc[i]));
        chk($sformatf("lb%0d_o_rs1", i+1), 64'(o_r1[i]), 64'(m_r1[i]));
        chk($sformatf("lb%0d_o_rs2", i+1), 64'(o_r2[i]), 64'(m_r2[i]));
        chk($sformatf("lb%0d_o_rd", i+1),  64'(o_rd[i]), 64'(m_rd[i]));
        chk($sformatf("lb%0d_o_rd_we", i+1), 64'(o_we[i]), 64'(m_we[i]));
        chk($sformatf("lb%0d_o_is_load", i+1), 64'(o_ld[i]), 64'(m_ld[i]));
      end
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) m_rf[r] = '0;
    for (int i = 0; i < 2; i++) begin
      m_ce[i] = 0; m_known[i] = 0; p_n[i] = 0; m_pc[i] = '0; m_r1[i] = '0; m_r2[i] = '0;
      m_a1[i] = '0; m_a2[i] = '0; m_rd[i] = '0; m_we[i] = 0; m_ld[i] = 0;
    end
    set_nop();
    rst = 1;
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      chk("reset_ce", 64'(o_ce[i]), 64'd0);
      chk("reset_pc", 64'(o_pc[i]), 64'd0);
      chk("reset_rs1", 64'(o_r1[i]), 64'd0);
      chk("reset_rd", 64'(o_rd[i]), 64'd0);
    end

    // write x5, then read it; also write x0 and read it
    set_nop(); set_wb(0, 5'd5, 32'hDEAD_BEEF); step();
    set_nop(); set_instr(32'h100, 5'd5, 1, 5'd0, 1, 5'd1, 1, 0); set_wb(0, 5'd0, 32'h1234_5678); step();
    chk("x5_read", 64'(o_r1[0]), 64'hDEAD_BEEF);
    set_nop(); set_instr(32'h104, 5'd0, 1, 5'd0, 1, 5'd1, 1, 0); step();
    chk("x0_read", 64'(o_r1[0]), 64'd0);

    // two ports to x7 in the same cycle as a read of x7
    set_nop(); set_instr(32'h108, 5'd7, 1, 5'd0, 0, 5'd2, 1, 0);
    set_wb(0, 5'd7, 32'h11); set_wb(1, 5'd7, 32'h22); step();
    chk("x7_bypass", 64'(o_r1[0]), 64'h22);
    set_nop(); set_instr(32'h10C, 5'd7, 1, 5'd0, 0, 5'd2, 1, 0); step();
    chk("x7_stored", 64'(o_r1[1]), 64'h22);

    // load rd=3, dependent add on rs2, with and without use_rs2
    for (int u = 1; u >= 0; u--) begin
      set_nop(); set_instr(32'h200, 5'd1, 1, 5'd0, 0, 5'd3, 1, 1); step();
      for (int c = 0; c < 3; c++) begin
        set_nop(); set_instr(32'h204, 5'd4, 1, 5'd3, logic'(u), 5'd6, 1, 0); step();
      end
    end

    // stall for 3 cycles with port 1 rewriting the held rs1
    set_nop(); set_instr(32'h300, 5'd9, 1, 5'd10, 1, 5'd11, 1, 0); step();
    for (int c = 0; c < 3; c++) begin
      set_nop(); i_stall = 1; set_instr(32'h304, 5'd1, 1, 5'd1, 1, 5'd2, 1, 0);
      if (c == 1) set_wb(1, 5'd9, 32'h55);
      step();
    end
    chk("held_refresh", 64'(o_r1[0]), 64'h55);
    chk("held_pc", 64'(o_pc[0]), 64'h300);

    // flush with stall and a pending hazard
    set_nop(); set_instr(32'h400, 5'd1, 1, 5'd0, 0, 5'd12, 1, 1); step();
    set_nop(); i_stall = 1; i_flush = 1; set_instr(32'h404, 5'd12, 1, 5'd0, 0, 5'd1, 1, 0); step();
    chk("flush_ce", 64'(o_ce[1]), 64'd0);
    set_nop(); set_instr(32'h408, 5'd12, 1, 5'd0, 0, 5'd1, 1, 0); step();

    // reset in the middle of a pending load-use bubble
    set_nop(); set_instr(32'h500, 5'd1, 1, 5'd0, 0, 5'd13, 1, 1); step();
    set_nop(); rst = 1; set_instr(32'h504, 5'd13, 1, 5'd0, 0, 5'd1, 1, 0); step();
    set_nop(); set_instr(32'h508, 5'd5, 1, 5'd13, 1, 5'd1, 1, 0); step();
    chk("rf_cleared", 64'(o_r1[0]), 64'd0);
    chk("no_bubble", 64'(o_ce[1]), 64'd1);

    // randomized traffic over a small register window
    for (int c = 0; c < 3000; c++) begin
      set_nop();
      rst = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 9) < 8)
        set_instr($urandom, 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
                  1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), ($urandom_range(0, 2) == 0));
      else begin
        i_pc = $urandom; rs1 = 5'($urandom); rs2 = 5'($urandom);
      end
      i_stall = ($urandom_range(0, 3) == 0);
      i_flush = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < NW; k++)
        if ($urandom_range(0, 1) == 1) set_wb(k, 5'($urandom_range(0, 7)), $urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
